// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer scheduler.
// Optional build macro: BUZZER_PREEMPT_EN (see buzzer_sched.sv).
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } buzz_state_e;

  // Tone half-period counts for a 50 MHz clock.
  localparam int unsigned L5 = 63776;
  localparam int unsigned L7 = 50618;
  localparam int unsigned M1 = 47774;
  localparam int unsigned M2 = 42568;
  localparam int unsigned M3 = 37919;
  localparam int unsigned M4 = 35791;
  localparam int unsigned M5 = 31888;

  // One quarter second at 50 MHz, a convenient note length.
  localparam int unsigned BEAT_250MS = 12_500_000;

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator for the buzzer.
// Toggles beep each time the count reaches the half-period; a half-period
// of zero is a rest and never toggles. Output is forced low when disabled.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int CNT_W = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] half_period_i,
  output logic             beep_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beep_q, beep_d;

  // Next count and beep level: clear at note start, otherwise count while enabled.
  always_comb begin
    cnt_d  = cnt_q;
    beep_d = beep_q;
    if (clr_i) begin
      cnt_d  = '0;
      beep_d = 1'b0;
    end else if (en_i && (half_period_i != '0)) begin
      if (cnt_q == half_period_i) begin
        cnt_d  = '0;
        beep_d = ~beep_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Tone counter and beep level registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      beep_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beep_q <= beep_d;
    end
  end

  assign beep_o = beep_q & en_i;

endmodule

// File: rtl/buzzer_sched.sv
// Fixed-priority note scheduler driving a single piezo buzzer.
// Index 0 is the highest priority requester. After each note (played to
// completion or cancelled) a silent gap of GAP_CYC cycles is inserted.
// Optional build macro: BUZZER_PREEMPT_EN - a higher-priority request aborts
// the playing note and is granted right after one idle cycle.
module buzzer_sched
  import buzzer_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int CNT_W   = 17,
  parameter int DUR_W   = 24,
  parameter int GAP_CYC = 500000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*CNT_W-1:0] half_period_i,
  input  logic [NREQ*DUR_W-1:0] dur_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [NREQ-1:0]       done_o,
  output logic                  busy_o,
  output logic                  beep_o
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam buzz_state_e AFTER_NOTE = (GAP_CYC > 0) ? GAP : IDLE;

  buzz_state_e      state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [DUR_W-1:0] durLast_q, durLast_d;
  logic [DUR_W-1:0] durCnt_q, durCnt_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic             toneClr;

  logic [NREQ-1:0]  pickOh;
  logic [CNT_W-1:0] pickHp;
  logic [DUR_W-1:0] pickDur;
  logic [DUR_W-1:0] pickLast;
  logic             grantLost;
  logic             preemptHit;

  // Arbiter: the lowest set request index wins; scanning downward lets it overwrite.
  always_comb begin
    pickOh  = '0;
    pickHp  = '0;
    pickDur = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        pickOh  = NREQ'(1) << i;
        pickHp  = half_period_i[i*CNT_W +: CNT_W];
        pickDur = dur_i[i*DUR_W +: DUR_W];
      end
    end
  end

  // A zero duration still plays for one cycle.
  assign pickLast  = (pickDur == '0) ? '0 : pickDur - 1'b1;
  assign grantLost = ~|(req_i & grant_q);

`ifdef BUZZER_PREEMPT_EN
  logic [NREQ-1:0] higherMask;
  // Bits strictly below the granted one-hot bit are the higher-priority requesters.
  assign higherMask = grant_q - NREQ'(1);
  assign preemptHit = |(req_i & higherMask);
`else
  assign preemptHit = 1'b0;
`endif

  // Next-state logic: arbitration in IDLE, note timing in PLAY, silence in GAP.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    hp_d      = hp_q;
    durLast_d = durLast_q;
    durCnt_d  = durCnt_q;
    gapCnt_d  = gapCnt_q;
    toneClr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d   = PLAY;
          grant_d   = pickOh;
          hp_d      = pickHp;
          durLast_d = pickLast;
          durCnt_d  = '0;
          toneClr   = 1'b1;
        end
      end
      PLAY: begin
        if (preemptHit) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (grantLost) begin
          state_d  = AFTER_NOTE;
          grant_d  = '0;
          gapCnt_d = '0;
        end else if (durCnt_q == durLast_q) begin
          state_d  = AFTER_NOTE;
          grant_d  = '0;
          done_d   = grant_q;
          gapCnt_d = '0;
        end else begin
          durCnt_d = durCnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, latched note parameters and counters; reset abandons any note in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      hp_q      <= '0;
      durLast_q <= '0;
      durCnt_q  <= '0;
      gapCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      hp_q      <= hp_d;
      durLast_q <= durLast_d;
      durCnt_q  <= durCnt_d;
      gapCnt_q  <= gapCnt_d;
    end
  end

  buzzer_tone_gen #(
    .CNT_W(CNT_W)
  ) u_tone (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (state_q == PLAY),
    .clr_i        (toneClr),
    .half_period_i(hp_q),
    .beep_o       (beep_o)
  );

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_buzzer_sched.sv
// Testbench for buzzer_sched with a four-cycle gap.
// Expected waveforms are computed note by note from arithmetic on the
// requested half-period and duration. Honours BUZZER_PREEMPT_EN.
module tb_buzzer_sched;

  localparam int NREQ  = 3;
  localparam int CNT_W = 17;
  localparam int DUR_W = 24;
  localparam int GAP   = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] hpBus;
  logic [NREQ*DUR_W-1:0] durBus;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  beep;

  int errors = 0;
  int checks = 0;

  buzzer_sched #(
    .NREQ   (NREQ),
    .CNT_W  (CNT_W),
    .DUR_W  (DUR_W),
    .GAP_CYC(GAP)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .half_period_i(hpBus),
    .dur_i        (durBus),
    .grant_o      (grant),
    .done_o       (done),
    .busy_o       (busy),
    .beep_o       (beep)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] eg, input logic [2:0] ed,
                          input logic eb, input logic ebp);
    checkOutput({tag, ".grant"}, 32'(grant), 32'(eg));
    checkOutput({tag, ".done"},  32'(done),  32'(ed));
    checkOutput({tag, ".busy"},  32'(busy),  32'(eb));
    checkOutput({tag, ".beep"},  32'(beep),  32'(ebp));
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [NREQ*CNT_W-1:0] hv,
                               input logic [NREQ*DUR_W-1:0] dv);
    req    = r;
    hpBus  = hv;
    durBus = dv;
  endtask

  function automatic logic [NREQ*CNT_W-1:0] hpv(input int a, input int b, input int c);
    return {CNT_W'(c), CNT_W'(b), CNT_W'(a)};
  endfunction

  function automatic logic [NREQ*DUR_W-1:0] dv3(input int a, input int b, input int c);
    return {DUR_W'(c), DUR_W'(b), DUR_W'(a)};
  endfunction

  function automatic int lowestIdx(input logic [2:0] m);
    for (int i = 0; i < NREQ; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Expected beep in cycle i of a note: toggles every hp+1 cycles, starting low.
  function automatic logic expBeep(input int hp, input int i);
    if (hp == 0) return 1'b0;
    return 1'((i / (hp + 1)) % 2);
  endfunction

  // Present a request from IDLE and follow the granted note through done, gap and idle.
  task automatic playNote(input string tag, input logic [2:0] r, input logic [NREQ*CNT_W-1:0] hv,
                          input logic [NREQ*DUR_W-1:0] dv, input int raiseAt,
                          input logic [2:0] raiseMask, input logic [2:0] gapReq, input bit scramble);
    int k, hp, d, len;
    logic [2:0] oh;
    k   = lowestIdx(r);
    hp  = int'(hv[k*CNT_W +: CNT_W]);
    d   = int'(dv[k*DUR_W +: DUR_W]);
    len = (d == 0) ? 1 : d;
    oh  = 3'(1 << k);
    applyStimulus(r, hv, dv);
    tick();
    for (int i = 0; i < len; i++) begin
      checkAll($sformatf("%s.c%0d", tag, i), oh, 3'b000, 1'b1, expBeep(hp, i));
      if (i == raiseAt) req = req | raiseMask;
      if (scramble) begin
        for (int j = 0; j < NREQ; j++) begin
          hpBus[j*CNT_W +: CNT_W]  = CNT_W'($urandom);
          durBus[j*DUR_W +: DUR_W] = DUR_W'($urandom_range(0, 40));
        end
      end
      tick();
    end
    checkAll({tag, ".done"}, 3'b000, oh, 1'b1, 1'b0);
    req = gapReq;
    for (int g = 1; g < GAP; g++) begin
      tick();
      checkAll($sformatf("%s.gap%0d", tag, g), 3'b000, 3'b000, 1'b1, 1'b0);
    end
    tick();
    checkAll({tag, ".idle"}, 3'b000, 3'b000, 1'b0, 1'b0);
  endtask

  // Present a request, then drop the granted bit so the note ends at cycle c with no done.
  task automatic cancelNote(input string tag, input logic [2:0] r, input logic [NREQ*CNT_W-1:0] hv,
                            input logic [NREQ*DUR_W-1:0] dv, input int c, input logic [2:0] gapReq);
    int k, hp;
    logic [2:0] oh;
    k  = lowestIdx(r);
    hp = int'(hv[k*CNT_W +: CNT_W]);
    oh = 3'(1 << k);
    applyStimulus(r, hv, dv);
    tick();
    for (int i = 0; i < c; i++) begin
      checkAll($sformatf("%s.c%0d", tag, i), oh, 3'b000, 1'b1, expBeep(hp, i));
      if (i == c - 1) req = r & ~oh;
      tick();
    end
    checkAll({tag, ".cancel"}, 3'b000, 3'b000, 1'b1, 1'b0);
    req = gapReq;
    for (int g = 1; g < GAP; g++) begin
      tick();
      checkAll($sformatf("%s.gap%0d", tag, g), 3'b000, 3'b000, 1'b1, 1'b0);
    end
    tick();
    checkAll({tag, ".idle"}, 3'b000, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] r;
    logic [NREQ*CNT_W-1:0] hv;
    logic [NREQ*DUR_W-1:0] dv;
    int k, d, len;

    // Power-on reset.
    rst = 1'b1;
    applyStimulus(3'b000, '0, '0);
    tick();
    tick();
    checkAll("por", 3'b000, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkAll("por.idle", 3'b000, 3'b000, 1'b0, 1'b0);

    // Reset in the middle of a note, then regrant once it is released.
    applyStimulus(3'b001, hpv(2, 0, 0), dv3(20, 0, 0));
    tick();
    checkAll("t1.start", 3'b001, 3'b000, 1'b1, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checkAll("t1.rst0", 3'b000, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    checkAll("t1.rst2", 3'b000, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    checkAll("t1.regrant", 3'b001, 3'b000, 1'b1, 1'b0);
    req = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checkAll("t1.clean", 3'b000, 3'b000, 1'b0, 1'b0);

    // Single tone note with latched inputs scrambled while it plays.
    playNote("t2", 3'b010, hpv(0, 2, 0), dv3(0, 12, 0), -1, 3'b000, 3'b000, 1'b1);

    // Two requests: lower index first, the other after the gap.
    playNote("t3a", 3'b110, hpv(0, 2, 1), dv3(0, 5, 7), -1, 3'b000, 3'b100, 1'b0);
    playNote("t3b", 3'b100, hpv(0, 2, 1), dv3(0, 5, 7), -1, 3'b000, 3'b000, 1'b0);

    // Rest note and zero duration.
    playNote("t4a", 3'b001, hpv(0, 0, 0), dv3(8, 0, 0), -1, 3'b000, 3'b000, 1'b0);
    playNote("t4b", 3'b001, hpv(3, 0, 0), dv3(0, 0, 0), -1, 3'b000, 3'b000, 1'b0);

    // Cancel at cycle 5.
    cancelNote("t5", 3'b001, hpv(1, 0, 0), dv3(20, 0, 0), 5, 3'b000);

`ifdef BUZZER_PREEMPT_EN
    // A higher-priority request aborts the note, then the lower one replays from the start.
    applyStimulus(3'b100, hpv(1, 0, 3), dv3(6, 0, 50));
    tick();
    for (int i = 0; i < 10; i++) begin
      checkAll($sformatf("t6.c%0d", i), 3'b100, 3'b000, 1'b1, expBeep(3, i));
      if (i == 9) req = 3'b101;
      tick();
    end
    checkAll("t6.abort", 3'b000, 3'b000, 1'b0, 1'b0);
    playNote("t6.hi", 3'b101, hpv(1, 0, 3), dv3(6, 0, 50), -1, 3'b000, 3'b100, 1'b0);
    playNote("t6.replay", 3'b100, hpv(1, 0, 3), dv3(6, 0, 50), -1, 3'b000, 3'b000, 1'b0);
`else
    // A higher-priority request arriving mid-note waits for done plus the gap.
    playNote("t6.lo", 3'b100, hpv(1, 0, 3), dv3(6, 0, 50), 10, 3'b001, 3'b101, 1'b0);
    playNote("t6.hi", 3'b101, hpv(1, 0, 3), dv3(6, 0, 50), -1, 3'b000, 3'b000, 1'b0);
`endif

    // Randomized notes and cancels.
    for (int n = 0; n < 24; n++) begin
      r  = 3'($urandom_range(1, 7));
      hv = hpv($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      dv = dv3($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
      k   = lowestIdx(r);
      d   = int'(dv[k*DUR_W +: DUR_W]);
      len = (d == 0) ? 1 : d;
      if (($urandom_range(0, 3) == 0) && (len >= 2)) begin
        cancelNote($sformatf("rnd%0d", n), r, hv, dv, $urandom_range(1, len - 1), 3'($urandom));
      end else begin
        playNote($sformatf("rnd%0d", n), r, hv, dv, -1, 3'b000, 3'($urandom), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buzzer_sched.md
Name: buzzer_sched

Overview:
- Schedules the single on-board piezo buzzer between several note requesters: key-click, melody player, alarm.
- Each requester presents one note at a time as a tone half-period plus a duration. The block arbitrates by fixed priority, plays the granted note, inserts an articulation gap, then re-arbitrates.
- Sits between the melody/alert logic and the top-level beep pin. Replaces per-song free-running tone counters with one shared, sequenced tone generator.

Parameters:
- NREQ, 3, number of requesters; index 0 has the highest priority.
- CNT_W, 17, width of the half-period count; 17 bits covers low-octave notes at 50 MHz.
- DUR_W, 24, width of the note duration in clk cycles; 250 ms = 12_500_000.
- GAP_CYC, 500000, number of silent cycles between notes (10 ms); 0 means no gap.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- req, input, NREQ, per-requester note request; level signal, held until done, or dropped to cancel.
- half_period, input, NREQ*CNT_W, packed per requester; beep toggles after half_period+1 cycles; 0 means rest (silent).
- dur, input, NREQ*DUR_W, packed per requester; note length in cycles; 0 is treated as 1.
- grant, output, NREQ, one-hot; marks the requester whose note is playing.
- done, output, NREQ, one-cycle pulse when the granted note completes.
- busy, output, 1, high whenever the state is not IDLE.
- beep, output, 1, buzzer drive.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; grant=0, done=0, busy=0, beep=0; all counters cleared. This applies even mid-note.
- States: IDLE, PLAY, GAP.
- IDLE:
  - If req!=0, pick the lowest set index k.
  - Next edge: latch half_period[k] and dur[k]; grant=onehot(k); clear tone and duration counters; go to PLAY.
  - Grant therefore appears one cycle after req is sampled.
- PLAY:
  - Duration counter runs from 0 to max(dur,1)-1.
  - On the final count: done[k]=1 for exactly one cycle, grant=0 in the same cycle, next state = GAP (or IDLE if GAP_CYC=0).
  - A played note lasts exactly max(dur,1) cycles with grant high.
- Cancel: if req[k] falls during PLAY, the next edge sets grant=0, issues no done, and moves to GAP/IDLE.
- GAP: beep=0 for GAP_CYC cycles, then IDLE. Requests arriving during GAP wait.
- Tone generator:
  - Counter cleared at note start; increments each PLAY cycle.
  - When count==latched half_period: count returns to 0 and beep toggles.
  - beep starts at 0 every note and is forced to 0 outside PLAY.
  - half_period==0 gives a silent rest of full duration; it does not toggle every cycle.
- Latched values are immune to input changes while the note plays.
- Tie rule: when several req bits are high in IDLE, only the lowest index is granted; the others stay pending.
- Only a low-to-high req is not required; a held req replays the next note after the gap. The requester advances its note on done.

Optional Feature:
- Macro: BUZZER_PREEMPT_EN.
- Defined:
  - In PLAY, if any req bit with index < k is high, the current note is aborted on the next edge: grant=0, no done[k], no gap, state=IDLE.
  - The higher requester is granted one cycle later.
  - Requester k stays pending and replays its note from the start later.
- Undefined: strictly non-preemptive; higher-priority requests wait for done/cancel plus the gap.

Decomposition:
- Package buzzer_pkg:
  - state enum {IDLE, PLAY, GAP}.
  - Note half-period constants at 50 MHz: L5=63776, L7=50618, M1=47774, M2=42568, M3=37919, M4=35791, M5=31888.
  - Constant BEAT_250MS=12_500_000.
- Sub-module buzzer_tone_gen: inputs clk, rst, en, clr, half_period; output beep. Holds the toggle counter and rest handling.
- buzzer_sched keeps the arbiter, the FSM, and the duration/gap counters.

Test Plan (CNT_W=17, DUR_W=24, GAP_CYC=4 unless stated):
1. rst held for 3 cycles mid-note with req=3'b001, hp=2, dur=20 -> next edge: beep=0, grant=0, busy=0; after rst drops, grant=001 one cycle later.
2. req[1] only, hp=2, dur=12 -> beep toggles every 3 cycles (period 6, 2 full periods); done[1] pulses at cycle 12 of grant; beep=0 for the 4 gap cycles.
3. req=3'b110 in IDLE -> grant=010 first; after done[1] and the 4-cycle gap, grant=100 if req[2] is still high.
4. hp=0, dur=8 -> beep stays 0 for 8 cycles with grant high, then done pulses. dur=0 -> note lasts 1 cycle.
5. req[0] dropped at cycle 5 of dur=20 -> grant falls, no done, 4-cycle gap, then IDLE.
6. BUZZER_PREEMPT_EN defined: req[2] playing (dur=50), req[0] rises at cycle 10 -> grant=000 for one cycle, then 001; no done[2]; req[2] replays from start after done[0] and the gap. Undefined: req[0] waits for done[2].
